// File: rtl/hs_link_param.sv
// hs_link_param: burst generator and receiver joined by an internal 4-phase
// req/ack handshake. The master sends len words (seed, seed+1, ...). The
// slave latches each word, pulses rx_valid and keeps a running checksum.
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   start         - begins a burst when sampled high while idle
//   len, seed     - word count and first word, sampled with start
//   rx_stall      - while high, the slave accepts no new word
//   busy, done    - burst in progress / one-cycle end-of-burst pulse
//   err           - sticky error (len too large or ack timeout)
//   rx_data       - last word accepted by the slave
//   rx_valid      - one-cycle pulse on each accept
//   rx_last       - high with rx_valid on the final word
//   checksum      - running sum of accepted words, mod 2^DATA_W
module hs_link_param #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned MAX_LEN   = 16,
   parameter int unsigned ACK_DELAY = 0,
   parameter int unsigned TIMEOUT   = 15
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [$clog2(MAX_LEN+1)-1:0]     len,
   input  logic [DATA_W-1:0]                seed,
   input  logic                             rx_stall,
   output logic                             busy,
   output logic                             done,
   output logic                             err,
   output logic [DATA_W-1:0]                rx_data,
   output logic                             rx_valid,
   output logic                             rx_last,
   output logic [DATA_W-1:0]                checksum
);

   localparam int unsigned LEN_W    = $clog2(MAX_LEN + 1);
   localparam int unsigned TO_W     = $clog2(TIMEOUT + 1);
   localparam int unsigned DLY_W    = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;
   localparam int unsigned DLY_LAST = (ACK_DELAY > 0) ? ACK_DELAY - 1 : 0;

   // The master must always outwait a healthy slave.
   if (TIMEOUT < ACK_DELAY + 2) begin : g_bad_timeout
      $error("hs_link_param: TIMEOUT must be >= ACK_DELAY+2");
   end

   typedef enum logic [1:0] {M_IDLE, M_REQ, M_WAIT_LOW, M_DONE} m_state_e;
   typedef enum logic [1:0] {S_IDLE, S_DELAY, S_ACK} s_state_e;

   m_state_e           m_state_q, m_state_d;
   s_state_e           s_state_q, s_state_d;
   logic               req_q, req_d;
   logic               ack_q, ack_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic [TO_W-1:0]    tcnt_q, tcnt_d;
   logic [DLY_W-1:0]   dcnt_q, dcnt_d;
   logic               stop_q, stop_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic [DATA_W-1:0]  rx_data_q, rx_data_d;
   logic               rx_valid_q, rx_valid_d;
   logic               rx_last_q, rx_last_d;
   logic [DATA_W-1:0]  checksum_q, checksum_d;
   logic               abort_c;
   logic               last_word_c;

   // Next-state and output logic for both FSMs.
   always_comb begin
      m_state_d  = m_state_q;
      s_state_d  = s_state_q;
      req_d      = req_q;
      ack_d      = ack_q;
      data_d     = data_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      tcnt_d     = tcnt_q;
      dcnt_d     = dcnt_q;
      stop_d     = stop_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = err_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      rx_last_d  = 1'b0;
      checksum_d = checksum_q;
      abort_c    = 1'b0;
      last_word_c = (cnt_q == LEN_W'(len_q - LEN_W'(1)));

      // Master. stop_q marks "finish after the current handshake settles";
      // it is how empty/oversized bursts and aborts reach M_DONE.
      unique case (m_state_q)
         M_IDLE: begin
            if (start) begin
               len_d      = len;
               data_d     = seed;
               cnt_d      = '0;
               tcnt_d     = '0;
               checksum_d = '0;
               err_d      = 1'b0;
               busy_d     = 1'b1;
               req_d      = 1'b0;
               if (len == '0) begin
                  stop_d    = 1'b1;
                  m_state_d = M_WAIT_LOW;
               end else if (32'(len) > MAX_LEN) begin
                  stop_d    = 1'b1;
                  err_d     = 1'b1;
                  m_state_d = M_WAIT_LOW;
               end else begin
                  stop_d    = 1'b0;
                  m_state_d = M_REQ;
               end
            end
         end
         M_REQ: begin
            req_d = 1'b1;
            if (ack_q) begin
               req_d     = 1'b0;
               m_state_d = M_WAIT_LOW;
            end else if (req_q) begin
               // Only cycles with req actually raised count toward the limit.
               if (tcnt_q == TO_W'(TIMEOUT - 1)) begin
                  abort_c   = 1'b1;
                  req_d     = 1'b0;
                  err_d     = 1'b1;
                  stop_d    = 1'b1;
                  m_state_d = M_WAIT_LOW;
               end else begin
                  tcnt_d = tcnt_q + TO_W'(1);
               end
            end
         end
         M_WAIT_LOW: begin
            if (!ack_q) begin
               if (stop_q || last_word_c) begin
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
                  m_state_d = M_DONE;
               end else begin
                  cnt_d     = cnt_q + LEN_W'(1);
                  data_d    = data_q + DATA_W'(1);
                  tcnt_d    = '0;
                  req_d     = 1'b1;
                  m_state_d = M_REQ;
               end
            end
         end
         M_DONE: m_state_d = M_IDLE;
         default: m_state_d = M_IDLE;
      endcase

      // Slave.
      unique case (s_state_q)
         S_IDLE: begin
            if (req_q && !rx_stall && !abort_c) begin
               rx_data_d  = data_q;
               rx_valid_d = 1'b1;
               rx_last_d  = last_word_c;
               checksum_d = checksum_q + data_q;
               if (ACK_DELAY == 0) begin
                  ack_d     = 1'b1;
                  s_state_d = S_ACK;
               end else begin
                  dcnt_d    = '0;
                  s_state_d = S_DELAY;
               end
            end
         end
         S_DELAY: begin
            if (dcnt_q == DLY_W'(DLY_LAST)) begin
               ack_d     = 1'b1;
               s_state_d = S_ACK;
            end else begin
               dcnt_d = dcnt_q + DLY_W'(1);
            end
         end
         S_ACK: begin
            if (!req_q) begin
               ack_d     = 1'b0;
               s_state_d = S_IDLE;
            end
         end
         default: s_state_d = S_IDLE;
      endcase

      // An abort pulls the slave back to idle regardless of where it was.
      if (abort_c) begin
         ack_d     = 1'b0;
         s_state_d = S_IDLE;
      end
   end

   // State register; reset wins over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_state_q  <= M_IDLE;
         s_state_q  <= S_IDLE;
         req_q      <= 1'b0;
         ack_q      <= 1'b0;
         data_q     <= '0;
         len_q      <= '0;
         cnt_q      <= '0;
         tcnt_q     <= '0;
         dcnt_q     <= '0;
         stop_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_last_q  <= 1'b0;
         checksum_q <= '0;
      end else begin
         m_state_q  <= m_state_d;
         s_state_q  <= s_state_d;
         req_q      <= req_d;
         ack_q      <= ack_d;
         data_q     <= data_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         tcnt_q     <= tcnt_d;
         dcnt_q     <= dcnt_d;
         stop_q     <= stop_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rx_last_q  <= rx_last_d;
         checksum_q <= checksum_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign rx_last  = rx_last_q;
   assign checksum = checksum_q;

endmodule

// File: tb/tb_hs_link_param.sv
// tb_hs_link_param: directed bench for hs_link_param. Two instances share
// clock/reset: u_dut0 (ACK_DELAY=0) and u_dut2 (ACK_DELAY=2); sel picks
// which one receives start and which one's outputs are observed.
module tb_hs_link_param;

   localparam int unsigned DW = 8;
   localparam int unsigned ML = 16;
   localparam int unsigned LW = $clog2(ML + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          sel = 1'b0;
   logic [LW-1:0] len = '0;
   logic [DW-1:0] seed = '0;
   logic          rx_stall = 1'b0;

   logic          start0, start2;
   logic          busy0, done0, err0, rxv0, rxl0;
   logic          busy2, done2, err2, rxv2, rxl2;
   logic [DW-1:0] rxd0, cs0, rxd2, cs2;
   logic          ob_busy, ob_done, ob_err, ob_rxv, ob_rxl, ob_req;
   logic [DW-1:0] ob_rxd, ob_cs;

   assign start0 = start & ~sel;
   assign start2 = start & sel;

   hs_link_param #(.DATA_W(DW), .MAX_LEN(ML), .ACK_DELAY(0), .TIMEOUT(15)) u_dut0 (
      .clk(clk), .rst(rst), .start(start0), .len(len), .seed(seed),
      .rx_stall(rx_stall), .busy(busy0), .done(done0), .err(err0),
      .rx_data(rxd0), .rx_valid(rxv0), .rx_last(rxl0), .checksum(cs0)
   );

   hs_link_param #(.DATA_W(DW), .MAX_LEN(ML), .ACK_DELAY(2), .TIMEOUT(15)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2), .len(len), .seed(seed),
      .rx_stall(rx_stall), .busy(busy2), .done(done2), .err(err2),
      .rx_data(rxd2), .rx_valid(rxv2), .rx_last(rxl2), .checksum(cs2)
   );

   assign ob_busy = sel ? busy2 : busy0;
   assign ob_done = sel ? done2 : done0;
   assign ob_err  = sel ? err2  : err0;
   assign ob_rxv  = sel ? rxv2  : rxv0;
   assign ob_rxl  = sel ? rxl2  : rxl0;
   assign ob_rxd  = sel ? rxd2  : rxd0;
   assign ob_cs   = sel ? cs2   : cs0;
   assign ob_req  = sel ? u_dut2.req_q : u_dut0.req_q;

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Results of the most recent burst.
   int            lat;
   int            nval;
   int            vk [8];
   logic [DW-1:0] vd [8];
   logic          vl [8];
   logic          err_done, busy_done, req_done;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called just after a negedge. Launches a burst, then watches outputs on
   // each negedge; k counts edges after the start edge E0. rx_stall is high
   // for edges E0+stall_from onward; start stays high through k=hold_k with
   // a different seed to show that it is ignored while busy.
   task automatic run(input logic s_dut, input logic [DW-1:0] s_seed,
                      input logic [LW-1:0] s_len, input int stall_from, input int hold_k);
      int k;
      bit got;
      for (int i = 0; i < 8; i++) begin
         vk[i] = -1; vd[i] = '0; vl[i] = 1'b0;
      end
      sel = s_dut; seed = s_seed; len = s_len; start = 1'b1;
      rx_stall = (stall_from <= 0);
      lat = -1; nval = 0; k = -1; got = 1'b0;
      err_done = 1'b0; busy_done = 1'b0; req_done = 1'b0;
      while (!got && k < 150) begin
         @(negedge clk);
         k++;
         if (k > hold_k) start = 1'b0;
         else seed = s_seed ^ 8'h55;
         rx_stall = (k + 1 >= stall_from);
         if (k == 0) check_eq("busy_after_start", 32'(ob_busy), 32'd1);
         if (ob_rxv) begin
            if (nval < 8) begin
               vk[nval] = k; vd[nval] = ob_rxd; vl[nval] = ob_rxl;
            end
            nval++;
         end
         if (ob_done) begin
            got = 1'b1; lat = k;
            err_done = ob_err; busy_done = ob_busy; req_done = ob_req;
         end
      end
      start = 1'b0; rx_stall = 1'b0;
      if (!got) check_eq("done_never_seen", 32'd0, 32'd1);
      @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_eq("rst_busy", 32'(busy0), 32'd0);
      check_eq("rst_done", 32'(done0), 32'd0);
      check_eq("rst_err", 32'(err0), 32'd0);
      check_eq("rst_rxv", 32'(rxv0), 32'd0);
      check_eq("rst_cs", 32'(cs0), 32'd0);
      check_eq("rst_rxd", 32'(rxd0), 32'd0);
      rst = 1'b0;

      // seed 0x10, len 3: start on first cycle out of reset.
      run(1'b0, 8'h10, LW'(3), 1000, -1);
      check_eq("t1_lat", 32'(lat), 32'd13);
      check_eq("t1_nval", 32'(nval), 32'd3);
      check_eq("t1_d0", 32'(vd[0]), 32'h10);
      check_eq("t1_d1", 32'(vd[1]), 32'h11);
      check_eq("t1_d2", 32'(vd[2]), 32'h12);
      check_eq("t1_l0", 32'(vl[0]), 32'd0);
      check_eq("t1_l1", 32'(vl[1]), 32'd0);
      check_eq("t1_l2", 32'(vl[2]), 32'd1);
      check_eq("t1_k0", 32'(vk[0]), 32'd2);
      check_eq("t1_k2", 32'(vk[2]), 32'd10);
      check_eq("t1_cs", 32'(ob_cs), 32'h33);
      check_eq("t1_err", 32'(err_done), 32'd0);
      check_eq("t1_busy_at_done", 32'(busy_done), 32'd0);
      check_eq("t1_rxd_hold", 32'(ob_rxd), 32'h12);

      // seed 0xFF wraps; start held high while busy with another seed.
      run(1'b0, 8'hFF, LW'(2), 1000, 4);
      check_eq("t2_lat", 32'(lat), 32'd9);
      check_eq("t2_nval", 32'(nval), 32'd2);
      check_eq("t2_d0", 32'(vd[0]), 32'hFF);
      check_eq("t2_d1", 32'(vd[1]), 32'h00);
      check_eq("t2_l1", 32'(vl[1]), 32'd1);
      check_eq("t2_cs", 32'(ob_cs), 32'hFF);
      check_eq("t2_err", 32'(err_done), 32'd0);

      // ACK_DELAY=2 instance, len 2.
      run(1'b1, 8'h05, LW'(2), 1000, -1);
      check_eq("t3_lat", 32'(lat), 32'd13);
      check_eq("t3_nval", 32'(nval), 32'd2);
      check_eq("t3_k0", 32'(vk[0]), 32'd2);
      check_eq("t3_spacing", 32'(vk[1] - vk[0]), 32'd6);
      check_eq("t3_cs", 32'(ob_cs), 32'h0B);
      check_eq("t3_err", 32'(err_done), 32'd0);

      // Stall from start: timeout abort with nothing delivered.
      run(1'b0, 8'h20, LW'(3), 0, -1);
      check_eq("t4_lat", 32'(lat), 32'd17);
      check_eq("t4_nval", 32'(nval), 32'd0);
      check_eq("t4_err", 32'(err_done), 32'd1);
      check_eq("t4_req", 32'(req_done), 32'd0);
      check_eq("t4_cs", 32'(ob_cs), 32'd0);
      check_eq("t4_busy_at_done", 32'(busy_done), 32'd0);

      // Stall after first word: checksum keeps the delivered word only.
      run(1'b0, 8'h21, LW'(3), 3, -1);
      check_eq("t5_lat", 32'(lat), 32'd21);
      check_eq("t5_nval", 32'(nval), 32'd1);
      check_eq("t5_err", 32'(err_done), 32'd1);
      check_eq("t5_cs", 32'(ob_cs), 32'h21);

      // Empty and oversized bursts.
      run(1'b0, 8'h33, LW'(0), 1000, -1);
      check_eq("t6_len0_lat", 32'(lat), 32'd1);
      check_eq("t6_len0_nval", 32'(nval), 32'd0);
      check_eq("t6_len0_err", 32'(err_done), 32'd0);
      run(1'b0, 8'h33, LW'(ML + 1), 1000, -1);
      check_eq("t6_big_lat", 32'(lat), 32'd1);
      check_eq("t6_big_nval", 32'(nval), 32'd0);
      check_eq("t6_big_err", 32'(err_done), 32'd1);

      // Reset in mid-burst after word 1 was accepted.
      sel = 1'b0; seed = 8'h30; len = LW'(3); start = 1'b1; rx_stall = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      check_eq("t7_cs_before_rst", 32'(cs0), 32'h61);
      rst = 1'b1;
      @(negedge clk);
      check_eq("t7_rst_busy", 32'(busy0), 32'd0);
      check_eq("t7_rst_done", 32'(done0), 32'd0);
      check_eq("t7_rst_err", 32'(err0), 32'd0);
      check_eq("t7_rst_rxv", 32'(rxv0), 32'd0);
      check_eq("t7_rst_rxl", 32'(rxl0), 32'd0);
      check_eq("t7_rst_rxd", 32'(rxd0), 32'd0);
      check_eq("t7_rst_cs", 32'(cs0), 32'd0);
      check_eq("t7_rst_req", 32'(u_dut0.req_q), 32'd0);
      rst = 1'b0;
      run(1'b0, 8'h40, LW'(1), 1000, -1);
      check_eq("t7_lat", 32'(lat), 32'd5);
      check_eq("t7_rxd", 32'(ob_rxd), 32'h40);
      check_eq("t7_cs", 32'(ob_cs), 32'h40);
      check_eq("t7_l0", 32'(vl[0]), 32'd1);
      check_eq("t7_err", 32'(err_done), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hs_link_param.md
HS_LINK_PARAM -- requirements
Module: hs_link_param

Interface
REQ-001 The module SHALL have a parameter DATA_W, default 8, giving the payload width in bits.
REQ-002 The module SHALL have a parameter MAX_LEN, default 16, giving the maximum number of words per burst.
REQ-003 The module SHALL have a parameter ACK_DELAY, default 0, giving the slave wait cycles between accepting a word and raising ack.
REQ-004 The module SHALL have a parameter TIMEOUT, default 15, giving the master wait limit in cycles for ack, and SHALL require TIMEOUT >= ACK_DELAY+2.
REQ-005 The module SHALL have a port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The module SHALL have a port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The module SHALL have a port start, input, 1 bit: begins a burst when sampled high while idle.
REQ-008 The module SHALL have a port len, input, $clog2(MAX_LEN+1) bits: word count, sampled together with start.
REQ-009 The module SHALL have a port seed, input, DATA_W bits: the first word value, sampled together with start.
REQ-010 The module SHALL have a port rx_stall, input, 1 bit: while high, the slave accepts no new word.
REQ-011 The module SHALL have a port busy, output, 1 bit: high from the start-accept cycle until done.
REQ-012 The module SHALL have a port done, output, 1 bit: a one-cycle pulse at burst end.
REQ-013 The module SHALL have a port err, output, 1 bit: sticky error flag.
REQ-014 The module SHALL have a port rx_data, output, DATA_W bits: the last word accepted by the slave.
REQ-015 The module SHALL have a port rx_valid, output, 1 bit: a one-cycle pulse on each slave accept.
REQ-016 The module SHALL have a port rx_last, output, 1 bit: high with rx_valid on the final word of a burst.
REQ-017 The module SHALL have a port checksum, output, DATA_W bits: the running sum of accepted words, mod 2^DATA_W.

Function
REQ-018 The module SHALL contain a master FSM (M_IDLE, M_REQ, M_WAIT_LOW, M_DONE) and a slave FSM (S_IDLE, S_DELAY, S_ACK), connected internally by a registered req, ack and DATA_W-bit data bus.
REQ-019 When start=1 in M_IDLE, the master SHALL latch len and seed, clear the word counter, checksum and err, and set busy.
REQ-020 The handshake SHALL be 4-phase: master raises req with data stable; slave raises ack; master drops req; slave drops ack; master sees ack=0 and then advances.
REQ-021 The slave SHALL accept a word when req=1 and rx_stall=0 in S_IDLE: it latches data into rx_data, pulses rx_valid and adds data to checksum.
REQ-022 After accepting a word, the slave SHALL spend ACK_DELAY cycles in S_DELAY, then assert ack in S_ACK until it samples req=0.
REQ-023 Word k (k = 0..len-1) SHALL carry the value seed+k mod 2^DATA_W, wrapping without error.
REQ-024 Timing: with start sampled at edge E0, req SHALL rise at E0+1, each word SHALL take 4+ACK_DELAY cycles when unstalled, and done SHALL be high for the cycle after edge E0+(4+ACK_DELAY)*len+1.
REQ-025 If len=0 at start, the module SHALL pulse done at E0+1, transfer no words, and leave err=0.
REQ-026 If len>MAX_LEN at start, the module SHALL set err=1, pulse done at E0+1, and transfer no words.
REQ-027 If ack stays 0 for TIMEOUT consecutive cycles in M_REQ, the module SHALL abort: drop req, force the slave to S_IDLE, suppress any accept in that cycle, set err=1, and pulse done on the next cycle.
REQ-028 After an abort, checksum SHALL hold the sum of the words delivered before the abort.
REQ-029 The module SHALL ignore start while busy=1.
REQ-030 checksum and rx_data SHALL hold their values after done until the next accepted start.
REQ-031 done and busy SHALL never be high in the same cycle, and busy SHALL fall in the done cycle.

Reset
REQ-032 When rst=1 at a clock edge, the module SHALL set both FSMs to idle and drive req, ack, busy, done, err, rx_valid, rx_last = 0 and rx_data, checksum and the word counter = 0.
REQ-033 The module SHALL give rst priority over all other inputs, including in mid-burst and abort cycles.
REQ-034 After rst deasserts, the module SHALL accept start on the first cycle.

Verification
REQ-035 Test: DATA_W=8, seed=0x10, len=3, ACK_DELAY=0 -> rx_data 0x10, 0x11, 0x12; rx_last on the third word; checksum=0x33; done 13 cycles after start; err=0.
REQ-036 Test: seed=0xFF, len=2 -> rx_data 0xFF then 0x00; checksum=0xFF; err=0.
REQ-037 Test: ACK_DELAY=2, len=2 -> done 13 cycles after start; rx_valid spacing 6 cycles.
REQ-038 Test: rx_stall=1 held from start, TIMEOUT=15 -> no rx_valid; err=1; done 17 cycles after start; req=0 after abort.
REQ-039 Test: len=0 -> done 1 cycle after start; err=0. Test: len=MAX_LEN+1 -> done 1 cycle after start; err=1.
REQ-040 Test: rst pulsed mid-burst after word 1 -> all outputs 0 next cycle; a new start with seed=0x40, len=1 -> rx_data=0x40; checksum=0x40.
